pixel_write_sink: RTL and testbench

- Receives the pixel-plot stream produced by the sprite draw engines: one `plot` strobe with `x`, `y` and 3-bit colour per pixel.
- Clips each pixel to the screen and converts it to a linear framebuffer address.
- Buffers accepted pixels in a FIFO and issues single-cycle framebuffer writes.
- Owns the full-screen clear sweep and reports overflow and clip statistics to the game controller.

---
 rtl/pixel_write_sink.sv | 157 +++++++++++++++
 tb/tb_pixel_write_sink.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_write_sink.sv
// Pixel write sink: clips the sprite plot stream, queues pixels in a FIFO and
// drains them to the framebuffer, with a full-screen clear sweep.
module pixel_write_sink #(
   parameter int         SCREEN_W   = 160,
   parameter int         SCREEN_H   = 120,
   parameter int         ADDR_W     = 15,
   parameter int         FIFO_DEPTH = 16,
   parameter logic [2:0] BG_COLOR   = 3'b000
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              plot_in,
   input  logic [9:0]        x_in,
   input  logic [9:0]        y_in,
   input  logic [2:0]        color_in,
   input  logic              clear_req,
   output logic              fb_we,
   output logic [ADDR_W-1:0] fb_addr,
   output logic [2:0]        fb_data,
   output logic              busy,
   output logic              clearing,
   output logic              clear_done,
   output logic              overflow,
   output logic [7:0]        clip_count
);

   localparam int NPIX  = SCREEN_W * SCREEN_H;
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int CLR_W = ADDR_W + 1;

   typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_CLEAR} state_t;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [2:0]        color;
   } entry_t;

   state_t            state;
   entry_t            mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  count;
   logic [CNT_W-1:0]  count_next;
   logic [CLR_W-1:0]  clear_ptr;

   logic              clipped;
   logic [ADDR_W-1:0] pix_addr;
   logic              clear_entry;
   logic              accept;
   logic              fifo_full;
   logic              push;
   logic              pop;

   assign clipped     = (int'(x_in) >= SCREEN_W) || (int'(y_in) >= SCREEN_H);
   assign pix_addr    = ADDR_W'(32'(y_in) * 32'(SCREEN_W) + 32'(x_in));
   assign clear_entry = clear_req && (state != S_CLEAR);
   // A plot arriving on the clear-entry edge belongs to the frame being erased.
   assign accept      = plot_in && !clipped && !clear_entry;
   assign fifo_full   = (count == CNT_W'(FIFO_DEPTH));
   assign push        = accept && !fifo_full;
   assign pop         = (state == S_DRAIN) && (count != '0) && !clear_entry;

   assign busy     = (state != S_IDLE) || (count != '0);
   assign clearing = (state == S_CLEAR);

   always_comb begin
      count_next = count;
      if (clear_entry)
         count_next = '0;
      else
         count_next = count + CNT_W'(push) - CNT_W'(pop);
   end

   // NOTE: FIFO storage has no reset; an entry is only read after it was written.
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= '{addr: pix_addr, color: color_in};
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // sees the pre-edge values of the others.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state      <= S_IDLE;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         clear_ptr  <= '0;
         fb_we      <= 1'b0;
         fb_addr    <= '0;
         fb_data    <= '0;
         clear_done <= 1'b0;
         overflow   <= 1'b0;
         clip_count <= '0;
      end else begin
         fb_we      <= 1'b0;
         clear_done <= 1'b0;
         count      <= count_next;

         if (push)
            wr_ptr <= wr_ptr + PTR_W'(1);

         if (pop) begin
            rd_ptr  <= rd_ptr + PTR_W'(1);
            fb_we   <= 1'b1;
            fb_addr <= mem[rd_ptr].addr;
            fb_data <= mem[rd_ptr].color;
         end

         if (clear_entry)
            overflow <= 1'b0;
         else if (accept && fifo_full)
            overflow <= 1'b1;

         if (plot_in && clipped && !clear_entry && clip_count != 8'hFF)
            clip_count <= clip_count + 8'd1;

         case (state)
            S_IDLE: begin
               if (count != '0)
                  state <= S_DRAIN;
            end
            S_DRAIN: begin
               if (count == '0)
                  state <= S_IDLE;
            end
            S_CLEAR: begin
               // Terminal cycle after the last write: no write, just the done pulse.
               if (clear_ptr == CLR_W'(NPIX)) begin
                  clear_ptr  <= '0;
                  clear_done <= 1'b1;
                  state      <= (count_next != '0) ? S_DRAIN : S_IDLE;
               end else begin
                  fb_we     <= 1'b1;
                  fb_addr   <= clear_ptr[ADDR_W-1:0];
                  fb_data   <= BG_COLOR;
                  clear_ptr <= clear_ptr + CLR_W'(1);
               end
            end
            default: state <= S_IDLE;
         endcase

         // The entry edge already issues the write of address 0.
         if (clear_entry) begin
            state     <= S_CLEAR;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fb_we     <= 1'b1;
            fb_addr   <= '0;
            fb_data   <= BG_COLOR;
            clear_ptr <= CLR_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_pixel_write_sink.sv
// Self-checking bench for pixel_write_sink: vector table, hand-written corner
// sequences and random plots against a queue-based reference model.
module tb_pixel_write_sink;

   localparam int W    = 160;
   localparam int H    = 120;
   localparam int NPIX = W * H;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        plot_in = 1'b0;
   logic [9:0]  x_in = '0;
   logic [9:0]  y_in = '0;
   logic [2:0]  color_in = '0;
   logic        clear_req = 1'b0;
   logic        fb_we;
   logic [14:0] fb_addr;
   logic [2:0]  fb_data;
   logic        busy;
   logic        clearing;
   logic        clear_done;
   logic        overflow;
   logic [7:0]  clip_count;

   pixel_write_sink #(
      .SCREEN_W(W), .SCREEN_H(H), .ADDR_W(15), .FIFO_DEPTH(16), .BG_COLOR(3'b000)
   ) dut (
      .clk(clk), .reset_n(reset_n), .plot_in(plot_in), .x_in(x_in), .y_in(y_in),
      .color_in(color_in), .clear_req(clear_req), .fb_we(fb_we), .fb_addr(fb_addr),
      .fb_data(fb_data), .busy(busy), .clearing(clearing), .clear_done(clear_done),
      .overflow(overflow), .clip_count(clip_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit we;
      int addr;
      int data;
      bit clearing;
      bit done;
      bit busy;
   } samp_t;

   typedef struct {
      int x;
      int y;
      int c;
      bit clip;
      int addr;
   } vec_t;

   samp_t log_q[$];
   int    n_done = 0;
   int    n_we = 0;
   int    exp_q[$];
   int    clip_model = 0;
   int    total = 0;
   int    bad = 0;
   int    first_addr;
   int    last_addr;

   always @(posedge clk) begin
      #1;
      if (clear_done) n_done++;
      if (fb_we) n_we++;
      log_q.push_back('{fb_we, int'(fb_addr), int'(fb_data), clearing, clear_done, busy});
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic drive(input int x, input int y, input int c);
      plot_in  = 1'b1;
      x_in     = 10'(x);
      y_in     = 10'(y);
      color_in = 3'(c);
   endtask

   // Reference: clipped pixels bump a saturating count, the rest are written in order.
   task automatic model_plot(input int x, input int y, input int c);
      if (x >= W || y >= H) begin
         if (clip_model < 255) clip_model++;
      end else begin
         exp_q.push_back((y * W + x) * 8 + c);
      end
   endtask

   task automatic do_reset();
      plot_in = 1'b0;
      clear_req = 1'b0;
      reset_n = 1'b0;
      repeat (2) tick();
      reset_n = 1'b1;
      clip_model = 0;
      exp_q.delete();
      tick();
   endtask

   task automatic wait_idle(input string tag);
      for (int i = 0; i < 100 && busy; i++) tick();
      check({tag, "_idle"}, busy, 0);
   endtask

   // Compare non-clear writes logged since base against exp_q.
   task automatic compare_writes(input string tag, input int base);
      int n = 0;
      int mism = 0;
      first_addr = -1;
      last_addr = -1;
      for (int i = base; i < log_q.size(); i++) begin
         if (log_q[i].we && !log_q[i].clearing) begin
            if (n < exp_q.size()) begin
               if (log_q[i].addr * 8 + log_q[i].data != exp_q[n]) mism++;
            end
            if (n == 0) first_addr = log_q[i].addr;
            last_addr = log_q[i].addr;
            n++;
         end
      end
      check({tag, "_nwrites"}, n, exp_q.size());
      check({tag, "_order"}, mism, 0);
   endtask

   task automatic wait_done(input string tag, input int d0);
      for (int i = 0; i < NPIX + 100 && n_done == d0; i++) tick();
      check({tag, "_done_seen"}, n_done - d0, 1);
   endtask

   initial begin
      vec_t vt[9];
      int   base;
      int   d0;
      int   w0;
      int   nw;
      int   seq_bad;
      int   last_w;
      int   done_idx;
      int   ndone;
      int   nclr;

      vt = '{'{5, 2, 5, 0, 325}, '{160, 0, 1, 1, 0}, '{0, 120, 2, 1, 0},
             '{159, 119, 7, 0, 19199}, '{0, 0, 3, 0, 0}, '{1023, 1023, 4, 1, 0},
             '{159, 0, 6, 0, 159}, '{0, 119, 1, 0, 19040}, '{100, 50, 2, 0, 8100}};

      // Reset state
      repeat (3) tick();
      check("rst_fb_we", fb_we, 0);
      check("rst_busy", busy, 0);
      check("rst_clearing", clearing, 0);
      check("rst_clear_done", clear_done, 0);
      check("rst_overflow", overflow, 0);
      check("rst_clip_count", clip_count, 0);
      reset_n = 1'b1;
      tick();

      // Single pixel latency: sampled at edge k, write visible after edge k+2
      drive(5, 2, 5);
      tick();
      plot_in = 1'b0;
      check("lat_k_we", fb_we, 0);
      tick();
      check("lat_k1_we", fb_we, 0);
      tick();
      check("lat_k2_we", fb_we, 1);
      check("lat_k2_addr", fb_addr, 325);
      check("lat_k2_data", fb_data, 5);
      tick();
      check("lat_k3_we", fb_we, 0);
      tick();
      check("lat_busy", busy, 0);

      // Vector table
      foreach (vt[v]) begin
         base = log_q.size();
         drive(vt[v].x, vt[v].y, vt[v].c);
         tick();
         plot_in = 1'b0;
         repeat (5) tick();
         nw = 0;
         for (int i = base; i < log_q.size(); i++) begin
            if (log_q[i].we) begin
               if (nw == 0) begin
                  check($sformatf("vec%0d_addr", v), log_q[i].addr, vt[v].addr);
                  check($sformatf("vec%0d_data", v), log_q[i].data, vt[v].c);
               end
               nw++;
            end
         end
         check($sformatf("vec%0d_nwr", v), nw, vt[v].clip ? 0 : 1);
         if (vt[v].clip && clip_model < 255) clip_model++;
         check($sformatf("vec%0d_clip", v), clip_count, clip_model);
      end

      // Saturation of the clip counter
      for (int i = 0; i < 300; i++) begin
         drive(200 + (i % 50), i % 200, i % 8);
         model_plot(200 + (i % 50), i % 200, i % 8);
         tick();
      end
      plot_in = 1'b0;
      tick();
      check("clip_sat", clip_count, 255);
      check("clip_sat_model", clip_count, clip_model);

      // Random plots against the reference model
      do_reset();
      check("rst2_clip", clip_count, 0);
      base = log_q.size();
      for (int i = 0; i < 2000; i++) begin
         if ($urandom_range(1, 0) == 1) begin
            int rx = $urandom_range(169, 0);
            int ry = $urandom_range(124, 0);
            int rc = $urandom_range(7, 0);
            drive(rx, ry, rc);
            model_plot(rx, ry, rc);
         end else begin
            plot_in = 1'b0;
         end
         tick();
      end
      plot_in = 1'b0;
      wait_idle("rand");
      repeat (3) tick();
      compare_writes("rand", base);
      check("rand_clip", clip_count, clip_model);
      check("rand_overflow", overflow, 0);

      // Full clear sweep
      base = log_q.size();
      d0 = n_done;
      clear_req = 1'b1;
      tick();
      clear_req = 1'b0;
      wait_done("clr", d0);
      repeat (5) tick();
      nw = 0; seq_bad = 0; last_w = -1; done_idx = -1; ndone = 0; nclr = 0;
      for (int i = base; i < log_q.size(); i++) begin
         if (log_q[i].we) begin
            if (log_q[i].addr != nw || log_q[i].data != 0 || !log_q[i].clearing) seq_bad++;
            nw++;
            last_w = i;
         end
         if (log_q[i].clearing) nclr++;
         if (log_q[i].done) begin
            ndone++;
            done_idx = i;
         end
      end
      check("clr_nwrites", nw, NPIX);
      check("clr_seq", seq_bad, 0);
      check("clr_clearing_cycles", nclr, NPIX);
      check("clr_ndone", ndone, 1);
      check("clr_done_after_last", done_idx, last_w + 1);
      check("clr_busy", busy, 0);

      // Overflow while clearing
      exp_q.delete();
      d0 = n_done;
      clear_req = 1'b1;
      tick();
      clear_req = 1'b0;
      repeat (10) tick();
      check("ovf_clearing", clearing, 1);
      base = log_q.size();
      for (int i = 0; i < 20; i++) begin
         drive(20 + i, 3 + (i % 2), i % 8);
         if (i < 16) exp_q.push_back(((3 + (i % 2)) * W + 20 + i) * 8 + (i % 8));
         tick();
      end
      plot_in = 1'b0;
      tick();
      check("ovf_set", overflow, 1);
      check("ovf_still_clearing", clearing, 1);
      wait_done("ovf", d0);
      wait_idle("ovf");
      compare_writes("ovf", base);
      check("ovf_sticky", overflow, 1);

      // New clear clears overflow; reset lands mid-clear with pixels queued
      w0 = n_we;
      clear_req = 1'b1;
      tick();
      clear_req = 1'b0;
      check("ovf_cleared", overflow, 0);
      for (int i = 0; i < 3; i++) begin
         drive(40 + i, 7, 3);
         tick();
      end
      plot_in = 1'b0;
      for (int i = 0; i < 1000 && (n_we - w0) < 500; i++) tick();
      check("rstclr_reached_500", n_we - w0, 500);
      reset_n = 1'b0;
      tick();
      check("rstclr_we", fb_we, 0);
      check("rstclr_clearing", clearing, 0);
      check("rstclr_busy", busy, 0);
      reset_n = 1'b1;
      clip_model = 0;
      exp_q.delete();
      base = log_q.size();
      repeat (40) tick();
      nw = 0;
      for (int i = base; i < log_q.size(); i++) if (log_q[i].we) nw++;
      check("rstclr_no_writes", nw, 0);
      check("rstclr_idle", busy, 0);

      // 32x32 sprite at (10,10), one plot every other cycle
      base = log_q.size();
      for (int r = 0; r < 32; r++) begin
         for (int c = 0; c < 32; c++) begin
            drive(10 + c, 10 + r, (r + c) % 8);
            model_plot(10 + c, 10 + r, (r + c) % 8);
            tick();
            plot_in = 1'b0;
            tick();
         end
      end
      wait_idle("sprite");
      repeat (3) tick();
      compare_writes("sprite", base);
      check("sprite_first", first_addr, 1610);
      check("sprite_last", last_addr, 6601);
      check("sprite_overflow", overflow, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
